// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//
// Forwarding and hazard-detection unit for the RISC-V core pipeline.
//
// A shift-register scoreboard of NSTAGE slots tracks the instructions that
// have left decode. Slot 0 is execute, and slot k is k cycles later. Each slot
// records:
//   - whether it holds a real instruction
//   - its destination register and write enable
//   - the first slot index from which its result can be forwarded
//
// For each operand of the instruction in decode, the unit:
//   - picks the youngest in-flight writer as the forwarding source
//   - raises a stall when that writer has not yet produced its result
//
// Ports
//   clk_i            core clock
//   rst_ni           asynchronous reset, active low
//   id_valid_i       decode holds a real instruction
//   id_rs1_i/rs2_i   source register indices
//   id_rs1_used_i    rs1 is actually read by the instruction
//   id_rs2_used_i    rs2 is actually read by the instruction
//   id_rd_i          destination register
//   id_rd_wen_i      instruction writes rd
//   id_class_i       result class: 0=ALU, 1=LOAD, 2=LONG, 3=reserved (as ALU)
//   pipe_hold_i      external freeze of the whole pipeline
//   flush_i          branch/jump taken in execute; kill the decode instruction
//   stall_o          decode and fetch must not advance (combinational)
//   fwd_rs1_sel_o    forward select for rs1 (combinational);
//                    0 = register file, k+1 = slot k
//   fwd_rs2_sel_o    forward select for rs2 (combinational), same encoding
//   fwd_rs1_sel_q_o  rs1 select registered into the execute stage
//   fwd_rs2_sel_q_o  rs2 select registered into the execute stage
//   stall_count_o    saturating count of hazard-stall cycles
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
    parameter int NSTAGE     = 3,
    parameter int LOAD_READY = 1,
    parameter int LONG_READY = 2,
    parameter int SELW       = 4,
    parameter int CNTW       = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            id_valid_i,
    input  logic [4:0]      id_rs1_i,
    input  logic [4:0]      id_rs2_i,
    input  logic            id_rs1_used_i,
    input  logic            id_rs2_used_i,
    input  logic [4:0]      id_rd_i,
    input  logic            id_rd_wen_i,
    input  logic [1:0]      id_class_i,
    input  logic            pipe_hold_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic [SELW-1:0] fwd_rs1_sel_o,
    output logic [SELW-1:0] fwd_rs2_sel_o,
    output logic [SELW-1:0] fwd_rs1_sel_q_o,
    output logic [SELW-1:0] fwd_rs2_sel_q_o,
    output logic [CNTW-1:0] stall_count_o
);

    localparam logic [1:0] CLS_LOAD = 2'd1;
    localparam logic [1:0] CLS_LONG = 2'd2;

    // -------------------------------------------------------------------------
    // Scoreboard state, packed so that an advance is a single shift.
    // -------------------------------------------------------------------------
    logic [NSTAGE-1:0]            slot_valid_q;
    logic [NSTAGE-1:0]            slot_wen_q;
    logic [NSTAGE-1:0][4:0]       slot_rd_q;
    logic [NSTAGE-1:0][SELW-1:0]  slot_rdy_q;

    logic [SELW-1:0]              fwd_rs1_sel_q;
    logic [SELW-1:0]              fwd_rs2_sel_q;
    logic [CNTW-1:0]              stall_count_q;

    // Combinational results.
    logic [NSTAGE-1:0]            rs1_match;
    logic [NSTAGE-1:0]            rs2_match;
    logic [SELW-1:0]              rs1_sel;
    logic [SELW-1:0]              rs2_sel;
    logic                         rs1_hazard;
    logic                         rs2_hazard;
    logic                         stall;
    logic                         insert;
    logic [SELW-1:0]              id_rdy;

    // Next-state values.
    logic [SELW-1:0]              fwd_rs1_sel_d;
    logic [SELW-1:0]              fwd_rs2_sel_d;
    logic [CNTW-1:0]              stall_count_d;

    // -------------------------------------------------------------------------
    // Per-slot match.
    // x0 is hard-wired to zero, so it never forwards. An operand the
    // instruction does not read can never create a dependency.
    // -------------------------------------------------------------------------
    always_comb begin
        rs1_match = '0;
        rs2_match = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            rs1_match[k] = slot_valid_q[k] & slot_wen_q[k] & id_rs1_used_i &
                           (id_rs1_i != 5'd0) & (slot_rd_q[k] == id_rs1_i);
            rs2_match[k] = slot_valid_q[k] & slot_wen_q[k] & id_rs2_used_i &
                           (id_rs2_i != 5'd0) & (slot_rd_q[k] == id_rs2_i);
        end
    end

    // -------------------------------------------------------------------------
    // Youngest-match priority.
    // Walking from the oldest slot to the youngest lets the smallest matching
    // index overwrite any older one, so shadowed writers are ignored. The
    // hazard is judged only against the selected (youngest) writer.
    // -------------------------------------------------------------------------
    always_comb begin
        rs1_sel    = '0;
        rs2_sel    = '0;
        rs1_hazard = 1'b0;
        rs2_hazard = 1'b0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (rs1_match[k]) begin
                rs1_sel    = SELW'(k + 1);
                rs1_hazard = (SELW'(k) < slot_rdy_q[k]);
            end
            if (rs2_match[k]) begin
                rs2_sel    = SELW'(k + 1);
                rs2_hazard = (SELW'(k) < slot_rdy_q[k]);
            end
        end
    end

    // A flush kills the decode instruction, so it can neither stall nor be
    // inserted. The stall is independent of pipe_hold; the hold only stops
    // the state from moving.
    assign stall  = id_valid_i & ~flush_i & (rs1_hazard | rs2_hazard);
    assign insert = id_valid_i & ~stall & ~flush_i;

    // First slot index from which the decode instruction's result will be
    // forwardable. The reserved class behaves like ALU.
    always_comb begin
        id_rdy = '0;
        unique case (id_class_i)
            CLS_LOAD: id_rdy = SELW'(LOAD_READY);
            CLS_LONG: id_rdy = SELW'(LONG_READY);
            default:  id_rdy = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state for the registered selects and the stall counter.
    // -------------------------------------------------------------------------
    always_comb begin
        fwd_rs1_sel_d = fwd_rs1_sel_q;
        fwd_rs2_sel_d = fwd_rs2_sel_q;
        stall_count_d = stall_count_q;
        if (!pipe_hold_i) begin
            fwd_rs1_sel_d = insert ? rs1_sel : '0;
            fwd_rs2_sel_d = insert ? rs2_sel : '0;
            if (stall && (stall_count_q != {CNTW{1'b1}})) begin
                stall_count_d = stall_count_q + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard shift.
    // A bubble is inserted at slot 0 whenever decode does not advance, so a
    // blocking entry moves one slot per advance. The stall therefore clears
    // in the same cycle the entry reaches its ready index, with no extra
    // penalty cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_valid_q <= '0;
            slot_wen_q   <= '0;
            slot_rd_q    <= '0;
            slot_rdy_q   <= '0;
        end else if (!pipe_hold_i) begin
            slot_valid_q <= {slot_valid_q[NSTAGE-2:0], insert};
            slot_wen_q   <= {slot_wen_q[NSTAGE-2:0], id_rd_wen_i};
            slot_rd_q    <= {slot_rd_q[NSTAGE-2:0], id_rd_i};
            slot_rdy_q   <= {slot_rdy_q[NSTAGE-2:0], id_rdy};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fwd_rs1_sel_q <= '0;
            fwd_rs2_sel_q <= '0;
            stall_count_q <= '0;
        end else begin
            fwd_rs1_sel_q <= fwd_rs1_sel_d;
            fwd_rs2_sel_q <= fwd_rs2_sel_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_o         = stall;
    assign fwd_rs1_sel_o   = rs1_sel;
    assign fwd_rs2_sel_o   = rs2_sel;
    assign fwd_rs1_sel_q_o = fwd_rs1_sel_q;
    assign fwd_rs2_sel_q_o = fwd_rs2_sel_q;
    assign stall_count_o   = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

    localparam int NSTAGE = 3;
    localparam int SELW   = 4;
    localparam int CNTW   = 3;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            id_valid_i;
    logic [4:0]      id_rs1_i, id_rs2_i, id_rd_i;
    logic            id_rs1_used_i, id_rs2_used_i, id_rd_wen_i;
    logic [1:0]      id_class_i;
    logic            pipe_hold_i, flush_i;
    logic            stall_o;
    logic [SELW-1:0] fwd_rs1_sel_o, fwd_rs2_sel_o, fwd_rs1_sel_q_o, fwd_rs2_sel_q_o;
    logic [CNTW-1:0] stall_count_o;

    int checks   = 0;
    int failures = 0;

    fwd_hazard_unit #(
        .NSTAGE(NSTAGE), .LOAD_READY(1), .LONG_READY(2), .SELW(SELW), .CNTW(CNTW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .id_rd_i(id_rd_i), .id_rd_wen_i(id_rd_wen_i), .id_class_i(id_class_i),
        .pipe_hold_i(pipe_hold_i), .flush_i(flush_i),
        .stall_o(stall_o),
        .fwd_rs1_sel_o(fwd_rs1_sel_o), .fwd_rs2_sel_o(fwd_rs2_sel_o),
        .fwd_rs1_sel_q_o(fwd_rs1_sel_q_o), .fwd_rs2_sel_q_o(fwd_rs2_sel_q_o),
        .stall_count_o(stall_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       valid;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       wen;
        logic [1:0] cls;
        logic       hold;
        logic       flush;
        logic       e_stall;
        int         e_s1, e_s2, e_q1, e_q2, e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input int rs1, input logic u1,
                                input int rs2, input logic u2, input int rd,
                                input logic wen, input int cls, input logic hold,
                                input logic flush, input logic st, input int s1,
                                input int s2, input int q1, input int q2, input int cnt);
        vec_t r;
        r.valid = v;   r.rs1 = 5'(rs1); r.u1 = u1; r.rs2 = 5'(rs2); r.u2 = u2;
        r.rd = 5'(rd); r.wen = wen; r.cls = 2'(cls); r.hold = hold; r.flush = flush;
        r.e_stall = st; r.e_s1 = s1; r.e_s2 = s2; r.e_q1 = q1; r.e_q2 = q2; r.e_cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int rs1, input logic u1, input int rs2,
                         input logic u2, input int rd, input logic wen, input int cls,
                         input logic hold, input logic flush);
        id_valid_i = v; id_rs1_i = 5'(rs1); id_rs1_used_i = u1;
        id_rs2_i = 5'(rs2); id_rs2_used_i = u2; id_rd_i = 5'(rd);
        id_rd_wen_i = wen; id_class_i = 2'(cls); pipe_hold_i = hold; flush_i = flush;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        string tag;
        int    n;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_ni = 1'b0;

        // Directed vectors, one per cycle.
        // Each record is: inputs -> expected comb outputs, then registered
        // outputs after the edge.
        // ALU chain: add x5 ; sub x6,x5,x5
        vecs.push_back(mk(1, 1,1, 2,1, 5,1,0, 0,0,  0,0,0, 0,0, 0));
        vecs.push_back(mk(1, 5,1, 5,1, 6,1,0, 0,0,  0,1,1, 1,1, 0));
        // Load-use: lw x7 ; add x8,x7,x1 (one bubble)
        vecs.push_back(mk(1, 2,1, 0,0, 7,1,1, 0,0,  0,0,0, 0,0, 0));
        vecs.push_back(mk(1, 7,1, 1,1, 8,1,0, 0,0,  1,1,0, 0,0, 1));
        vecs.push_back(mk(1, 7,1, 1,1, 8,1,0, 0,0,  0,2,0, 2,0, 1));
        // Two writers of x3, then or x4,x3,x0
        vecs.push_back(mk(1, 1,1, 0,0, 3,1,0, 0,0,  0,0,0, 0,0, 1));
        vecs.push_back(mk(1, 1,1, 0,0, 3,1,0, 0,0,  0,0,0, 0,0, 1));
        vecs.push_back(mk(1, 3,1, 0,1, 4,1,0, 0,0,  0,1,0, 1,0, 1));
        // LONG x9, consumer with a 3-cycle hold in the middle
        vecs.push_back(mk(1,10,1,11,1, 9,1,2, 0,0,  0,0,0, 0,0, 1));
        vecs.push_back(mk(1, 9,1, 9,1,12,1,0, 0,0,  1,1,1, 0,0, 2));
        vecs.push_back(mk(1, 9,1, 9,1,12,1,0, 1,0,  1,2,2, 0,0, 2));
        vecs.push_back(mk(1, 9,1, 9,1,12,1,0, 1,0,  1,2,2, 0,0, 2));
        vecs.push_back(mk(1, 9,1, 9,1,12,1,0, 1,0,  1,2,2, 0,0, 2));
        vecs.push_back(mk(1, 9,1, 9,1,12,1,0, 0,0,  1,2,2, 0,0, 3));
        vecs.push_back(mk(1, 9,1, 9,1,12,1,0, 0,0,  0,3,3, 3,3, 3));
        // Load-use with flush in the same cycle, then a consumer of the killed rd
        vecs.push_back(mk(1, 1,1, 0,0,13,1,1, 0,0,  0,0,0, 0,0, 3));
        vecs.push_back(mk(1,13,1, 0,1,14,1,0, 0,1,  0,1,0, 0,0, 3));
        vecs.push_back(mk(1,14,1,13,1,15,1,0, 0,0,  0,0,2, 0,2, 3));
        // Invalid decode: select visible, but nothing is inserted
        vecs.push_back(mk(0,15,1, 0,0, 0,0,0, 0,0,  0,1,0, 0,0, 3));
        // A writer of x0 never forwards
        vecs.push_back(mk(1, 1,1, 0,0, 0,1,0, 0,0,  0,0,0, 0,0, 3));
        vecs.push_back(mk(1, 0,1,15,1,16,1,0, 0,0,  0,0,3, 0,3, 3));

        #12 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("reset_stall", int'(stall_o), 0);
        chk("reset_sel1",  int'(fwd_rs1_sel_o), 0);
        chk("reset_q1",    int'(fwd_rs1_sel_q_o), 0);
        chk("reset_q2",    int'(fwd_rs2_sel_q_o), 0);
        chk("reset_cnt",   int'(stall_count_o), 0);
        tick();

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            drive(v.valid, int'(v.rs1), v.u1, int'(v.rs2), v.u2, int'(v.rd), v.wen,
                  int'(v.cls), v.hold, v.flush);
            #1;
            tag = $sformatf("v%0d", i);
            chk({tag, "_stall"}, int'(stall_o), int'(v.e_stall));
            chk({tag, "_sel1"},  int'(fwd_rs1_sel_o), v.e_s1);
            chk({tag, "_sel2"},  int'(fwd_rs2_sel_o), v.e_s2);
            tick();
            chk({tag, "_q1"},  int'(fwd_rs1_sel_q_o), v.e_q1);
            chk({tag, "_q2"},  int'(fwd_rs2_sel_q_o), v.e_q2);
            chk({tag, "_cnt"}, int'(stall_count_o), v.e_cnt);
        end

        // Asynchronous reset in the middle of a load-use stall.
        // Slots: x16 at slot 0. lw x20,x16 forwards from slot 0.
        drive(1, 16, 1, 0, 0, 20, 1, 1, 0, 0);
        tick();
        chk("pre_rst_q1", int'(fwd_rs1_sel_q_o), 1);
        drive(1, 20, 1, 0, 0, 21, 1, 0, 0, 0);
        #1;
        chk("pre_rst_stall", int'(stall_o), 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_stall", int'(stall_o), 0);
        chk("rst_sel1",  int'(fwd_rs1_sel_o), 0);
        chk("rst_q1",    int'(fwd_rs1_sel_q_o), 0);
        chk("rst_cnt",   int'(stall_count_o), 0);
        #2 rst_ni = 1'b1;
        #1;
        chk("post_rst_stall", int'(stall_o), 0);
        chk("post_rst_sel1",  int'(fwd_rs1_sel_o), 0);
        tick();

        // Repeated LONG-use pairs: two stalls each, counter saturates at 7.
        for (int i = 0; i < 5; i++) begin
            int exp_cnt;
            drive(1, 0, 0, 0, 0, 22, 1, 2, 0, 0);
            tick();
            drive(1, 22, 1, 0, 0, 23, 1, 0, 0, 0);
            #1;
            n = 0;
            while (stall_o && n < 6) begin
                tick();
                n++;
            end
            chk($sformatf("long%0d_bubbles", i), n, 2);
            chk($sformatf("long%0d_sel1", i), int'(fwd_rs1_sel_o), 3);
            tick();
            exp_cnt = (2 * (i + 1) > 7) ? 7 : 2 * (i + 1);
            chk($sformatf("long%0d_cnt", i), int'(stall_count_o), exp_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard-detection unit for the RISC-V core.
- Tracks in-flight register writes in a shift-register scoreboard of NSTAGE slots behind decode.
- For the instruction in decode, selects the youngest forwarding source per operand and stalls when a needed result is not yet produced (loads, long-latency ops).
- Handles external pipeline hold and branch flush, and keeps a saturating stall counter.

Parameters:
- NSTAGE, 3: scoreboard slots after decode. Slot 0 is execute, slot k is k cycles later. Range 2..8.
- LOAD_READY, 1: first slot index from which a LOAD result can be forwarded. Must be < NSTAGE.
- LONG_READY, 2: first slot index from which a LONG-class result can be forwarded. Must be < NSTAGE.
- SELW, 4: width of the forward-select fields. Must satisfy 2^SELW > NSTAGE.
- CNTW, 32: stall counter width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous reset, active-low.
- id_valid  in  1  decode holds a real instruction.
- id_rs1, id_rs2  in  5 each  source register indices.
- id_rs1_used, id_rs2_used  in  1 each  operand is actually read.
- id_rd  in  5  destination register.
- id_rd_wen  in  1  instruction writes rd.
- id_class  in  2  result class: 0=ALU (ready at slot 0), 1=LOAD, 2=LONG, 3=reserved (treated as ALU).
- pipe_hold  in  1  external freeze (e.g. memory wait).
- flush  in  1  branch or jump taken in execute; kill the decode instruction.
- stall  out  1  combinational; decode and fetch must not advance.
- fwd_rs1_sel, fwd_rs2_sel  out  SELW each  combinational; 0 = register file, k+1 = result from slot k.
- fwd_rs1_sel_q, fwd_rs2_sel_q  out  SELW each  registered selects aligned with the execute stage.
- stall_count  out  CNTW  saturating count of hazard-stall cycles.

Behaviour:
- Slot state: valid, rd, wen, rdy (forwardable slot index: 0, LOAD_READY or LONG_READY by class).
- Match at slot k for operand rs: valid & wen & rd==rs & rs!=0 & operand used.
- Forward select is k+1 for the smallest matching k, otherwise 0.
  - Only the youngest match counts; older matches are shadowed.
  - x0 never matches.
- Hazard: an operand's selected slot k satisfies k < rdy of that slot. Evaluated independently per operand.
  - stall = id_valid & ~flush & (hazard on rs1 | hazard on rs2).
  - stall does not depend on pipe_hold.
- Advance, when pipe_hold=0:
  - Slots shift, slot[k+1] <= slot[k].
  - Slot[NSTAGE-1] is discarded.
  - slot[0] <= decode instruction if id_valid & ~stall & ~flush; otherwise a bubble (valid=0).
- When pipe_hold=1: all slots and the registered selects are frozen, and stall_count does not increment.
- fwd_*_sel_q: on advance, load the combinational select if an instruction is inserted, else 0.
- stall_count: increments on each cycle with stall=1 & pipe_hold=0; saturates at all-ones.
- flush and a hazard in the same cycle: flush wins, so stall=0 and a bubble is inserted.
- A multi-cycle stall resolves with no extra penalty. The blocking entry moves one slot per advance, and stall drops in the cycle its slot index reaches rdy.
  - Example: a LOAD followed by a dependent ALU op with LOAD_READY=1 gives exactly 1 bubble.
  - Example: the same pair with LONG_READY=2 gives 2 bubbles.
- Reset (rst low, asynchronous): all slots invalid, fwd_*_sel_q=0, stall_count=0. Combinational outputs then read 0 or register file unless decode inputs create a match (impossible with empty slots).
- Reset deasserted mid-stream: the scoreboard starts empty; no forwarding to pre-reset instructions.
- Edge case: id_rd == id_rs1 in the same instruction does not self-match, because slots hold only older instructions.

Test Plan:
- ALU chain `add x5,...` then `sub x6,x5,x5` (NSTAGE=3) -> stall=0; fwd_rs1_sel=fwd_rs2_sel=1. Next cycle fwd_rs1_sel_q=1.
- Load-use `lw x7` then `add x8,x7,x1` (LOAD_READY=1) -> stall=1 for exactly 1 cycle, then fwd_rs1_sel=2, fwd_rs2_sel=0; stall_count=1.
- Two writers `addi x3` and `addi x3` back-to-back, then `or x4,x3,x0` -> fwd_rs1_sel=1 (youngest), never 2; rs2 (x0) select=0.
- LONG op writing x9, then a consumer of x9 (LONG_READY=2) -> 2 stall cycles. Hold pipe_hold=1 for 3 cycles in the middle -> stall stays 1, stall_count frozen during hold, final stall_count=2.
- Load-use hazard with flush=1 in the same cycle -> stall=0, bubble inserted, a later consumer sees no slot for the killed instruction.
- Drive rst low asynchronously mid-stall -> slots cleared immediately, stall=0, stall_count=0, fwd_*_sel_q=0. Force stall_count to all-ones -> further stalls do not wrap.
